// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the pipelined ALU.
// Optional multiplier is enabled with `define ALU_MUL_EN.
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_PASSB = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_MERGE = 4'd3;
   localparam logic [3:0] OP_SHL   = 4'd4;
   localparam logic [3:0] OP_SUB   = 4'd5;
   localparam logic [3:0] OP_OR    = 4'd6;
   localparam logic [3:0] OP_XOR   = 4'd7;
   localparam logic [3:0] OP_SHR   = 4'd8;
   localparam logic [3:0] OP_SRA   = 4'd9;
   localparam logic [3:0] OP_MUL   = 4'd10;
   localparam logic [3:0] OP_CMP   = 4'd11;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles,
// low WIDTH bits of the unsigned product. Built only under ALU_MUL_EN.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] step;
   logic [CW-1:0]    count;
   logic             busy_q;

   // The final step is presented combinationally so the result lands on the last busy edge.
   assign step    = acc + (mplier[0] ? mcand : '0);
   assign product = step;
   assign busy    = busy_q;
   assign done    = busy_q && (count == CW'(1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         count  <= CW'(WIDTH);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         acc    <= step;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - 1'b1;
         if (count == CW'(1)) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with a one-entry registered output stage.
// `define ALU_MUL_EN adds the iterative multiplier (OP 10); otherwise OP 10 is illegal.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [3:0]       OP,
   input  logic [WIDTH-1:0] INPUTA,
   input  logic [WIDTH-1:0] INPUTB,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] OUT,
   output logic             ZERO,
   output logic             EQUAL,
   output logic             CARRY,
   output logic             NEG,
   output logic             OVF,
   output logic             ILLEGAL
);

   localparam int H = WIDTH / 2;

   state_t           state;
   state_t           next_state;
   logic             in_ready;
   logic             accept;
   logic             is_mul;
   logic             load_alu;
   logic             drain;
   logic [WIDTH-1:0] res;
   logic             res_carry;
   logic             res_ovf;
   logic             res_illegal;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             shift_big;
   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] out_q;
   logic             out_valid_q;
   logic             zero_q;
   logic             equal_q;
   logic             carry_q;
   logic             ovf_q;
   logic             illegal_q;

`ifdef ALU_MUL_EN
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   assign mul_start = accept && is_mul;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .start   (mul_start),
      .a       (INPUTA),
      .b       (INPUTB),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
`ifdef ALU_MUL_EN
      case (state)
         ST_IDLE:     if (accept && is_mul) next_state = ST_MUL_BUSY;
         ST_MUL_BUSY: if (mul_done) next_state = ST_IDLE;
         default:     next_state = ST_IDLE;
      endcase
`else
      next_state = ST_IDLE;
`endif
   end

   always_comb begin
      in_ready = RST_N && (state == ST_IDLE) && (!out_valid_q || OUT_READY);
      is_mul   = 1'b0;
`ifdef ALU_MUL_EN
      in_ready = in_ready && !mul_busy;
      is_mul   = (OP == OP_MUL);
`endif
      accept   = IN_VALID && in_ready;
      load_alu = accept && !is_mul;
   end

   assign drain = out_valid_q && OUT_READY;

   always_comb begin
      res         = '0;
      res_carry   = 1'b0;
      res_ovf     = 1'b0;
      res_illegal = 1'b0;
      sum         = {1'b0, INPUTA} + {1'b0, INPUTB};
      diff        = {1'b0, INPUTA} - {1'b0, INPUTB};
      // Shift amount is the whole of A, so anything past the datapath saturates.
      shift_big   = (INPUTA >= WIDTH'(WIDTH));
      sh          = INPUTA[SHW-1:0];
      case (OP)
         OP_AND:   res = INPUTA & INPUTB;
         OP_PASSB: res = INPUTB;
         OP_ADD: begin
            res       = sum[WIDTH-1:0];
            res_carry = sum[WIDTH];
            res_ovf   = (INPUTA[WIDTH-1] == INPUTB[WIDTH-1]) && (sum[WIDTH-1] != INPUTA[WIDTH-1]);
         end
         OP_MERGE: res = {INPUTA[H-1:0], INPUTB[WIDTH-1:H]};
         OP_SHL:   res = shift_big ? '0 : (INPUTB << sh);
         OP_SUB, OP_CMP: begin
            res       = (OP == OP_SUB) ? diff[WIDTH-1:0] : '0;
            res_carry = !diff[WIDTH];
            res_ovf   = (INPUTA[WIDTH-1] != INPUTB[WIDTH-1]) && (diff[WIDTH-1] != INPUTA[WIDTH-1]);
         end
         OP_OR:    res = INPUTA | INPUTB;
         OP_XOR:   res = INPUTA ^ INPUTB;
         OP_SHR:   res = shift_big ? '0 : (INPUTB >> sh);
         OP_SRA:   res = shift_big ? {WIDTH{INPUTB[WIDTH-1]}} : WIDTH'($signed(INPUTB) >>> sh);
         default:  res_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b0;
         equal_q     <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         if (accept) equal_q <= (INPUTA == INPUTB);
         if (load_alu) begin
            out_q       <= res;
            zero_q      <= (res == '0);
            carry_q     <= res_carry;
            ovf_q       <= res_ovf;
            illegal_q   <= res_illegal;
            out_valid_q <= 1'b1;
         end
`ifdef ALU_MUL_EN
         else if (mul_done) begin
            out_q       <= mul_product;
            zero_q      <= (mul_product == '0);
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
         end
`endif
         else if (drain) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign IN_READY  = in_ready;
   assign OUT_VALID = out_valid_q;
   assign OUT       = out_q;
   assign ZERO      = zero_q;
   assign EQUAL     = equal_q;
   assign CARRY     = carry_q;
   assign NEG       = out_q[WIDTH-1];
   assign OVF       = ovf_q;
   assign ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=16); expectations follow ALU_MUL_EN if defined.
module tb_alu_pipe;

   localparam int W = 16;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          IN_VALID = 1'b0;
   logic          OUT_READY = 1'b0;
   logic [3:0]    OP = '0;
   logic [W-1:0]  INPUTA = '0;
   logic [W-1:0]  INPUTB = '0;
   logic          IN_READY, OUT_VALID, ZERO, EQUAL, CARRY, NEG, OVF, ILLEGAL;
   logic [W-1:0]  OUT;

   alu_pipe #(.WIDTH(W)) dut (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .OP(OP), .INPUTA(INPUTA), .INPUTB(INPUTB), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY), .OUT(OUT), .ZERO(ZERO), .EQUAL(EQUAL),
      .CARRY(CARRY), .NEG(NEG), .OVF(OVF), .ILLEGAL(ILLEGAL)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [W-1:0] out;
      logic         zero, equal, carry, neg, ovf, illegal;
      int           lat;
      int           acc_cyc;
      int           op, a, b;
   } exp_t;

   exp_t sbq[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   bit   rdy_rand  = 1'b0;
   bit   rdy_force = 1'b1;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int sgn(input int v);
      return (v >= 32768) ? v - 65536 : v;
   endfunction

   // Behavioural reference: integer arithmetic straight from the opcode table.
   function automatic exp_t model(input int op, input int a, input int b);
      exp_t e;
      int r, sa, sb, s;
      sa = sgn(a);
      sb = sgn(b);
      r = 0;
      e.carry = 0; e.ovf = 0; e.illegal = 0; e.lat = 1;
      case (op)
         0:  r = a & b;
         1:  r = b;
         2: begin
            r = a + b;
            e.carry = (r > 65535);
            e.ovf = (sa + sb > 32767) || (sa + sb < -32768);
         end
         3:  r = (a % 256) * 256 + b / 256;
         4:  r = (a >= 16) ? 0 : (b * (1 << a));
         5, 11: begin
            r = (op == 5) ? a - b : 0;
            e.carry = (a >= b);
            e.ovf = (sa - sb > 32767) || (sa - sb < -32768);
         end
         6:  r = a | b;
         7:  r = a ^ b;
         8:  r = (a >= 16) ? 0 : (b / (1 << a));
         9: begin
            if (a >= 16) r = (sb < 0) ? 65535 : 0;
            else begin
               s = sb;
               r = s >>> a;
            end
         end
         10: begin
            if (MUL_EN) begin
               r = int'((longint'(a) * longint'(b)) % 65536);
               e.lat = 17;
            end else e.illegal = 1;
         end
         default: e.illegal = 1;
      endcase
      r = r & 65535;
      e.out = 16'(r);
      e.zero = (r == 0);
      e.neg = (r >= 32768);
      e.equal = (a == b);
      e.op = op; e.a = a; e.b = b;
      return e;
   endfunction

   task automatic issue(input int op, input int a, input int b, output int waited);
      exp_t e;
      waited = 0;
      @(negedge CLK);
      IN_VALID = 1'b1;
      OP = 4'(op);
      INPUTA = 16'(a);
      INPUTB = 16'(b);
      #3;
      while (!IN_READY && waited < 200) begin
         @(negedge CLK);
         #3;
         waited++;
      end
      if (!IN_READY) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: op=%0d IN_READY stuck at %0b, required 1", op, IN_READY);
         IN_VALID = 1'b0;
         return;
      end
      e = model(op, a, b);
      e.acc_cyc = cyc + 1;
      sbq.push_back(e);
      @(posedge CLK);
      #1 IN_VALID = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sbq.size() != 0 && n < budget) begin
         @(negedge CLK);
         n++;
      end
      chk("drain_queue_empty", sbq.size(), 0);
   endtask

   // Monitor: owns OUT_READY, checks latency on first presentation and contents on transfer.
   initial begin
      bit            prev_hold = 1'b0;
      logic [21:0]   prev_snap = '0;
      logic [21:0]   snap, want;
      exp_t          h;
      forever begin
         @(negedge CLK);
         #1 OUT_READY = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
         #1;
         snap = {OUT, ZERO, EQUAL, CARRY, NEG, OVF, ILLEGAL};
         if (RST_N && OUT_VALID) begin
            if (prev_hold) chk("hold_stable", snap, prev_snap);
            if (sbq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_output: got %0h with empty scoreboard", snap);
            end else begin
               h = sbq[0];
               if (!prev_hold) chk($sformatf("latency op=%0d", h.op), cyc - h.acc_cyc + 1, h.lat);
               if (OUT_READY) begin
                  void'(sbq.pop_front());
                  want = {h.out, h.zero, h.equal, h.carry, h.neg, h.ovf, h.illegal};
                  chk($sformatf("result op=%0d a=%0h b=%0h {out,z,eq,c,n,v,ill}", h.op, h.a, h.b),
                      snap, want);
               end
            end
         end
         prev_hold = RST_N && OUT_VALID && !OUT_READY;
         prev_snap = snap;
      end
   end

   initial begin
      int w;
      int op, a, b;
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      #3 chk("reset_outputs", {IN_READY, OUT_VALID, OUT, ZERO, EQUAL, CARRY, NEG, OVF, ILLEGAL}, 0);
      @(negedge CLK);
      RST_N = 1'b1;

      rdy_force = 1'b1;
      issue(2, 'hFFFF, 'h0001, w);
      issue(5, 'h8000, 'h0001, w);
      issue(11, 'h0003, 'h0005, w);
      issue(4, 4, 'h00F1, w);
      issue(4, 16, 'h00F1, w);
      issue(9, 20, 'h8000, w);
      issue(3, 'h12AB, 'hCD34, w);
      issue(8, 3, 'hF0F0, w);
      issue(9, 3, 'h8010, w);
      issue(11, 'h1234, 'h1234, w);
      for (int i = 12; i < 16; i++) issue(i, 'h0101, 'h0202, w);
      issue(0, 'hFF00, 'h0FF0, w);
      chk("legal_after_illegal_no_stall", w, 0);

      wait_drain(50);
      issue(10, 'h0012, 'h0034, w);
      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         #3 chk("in_ready_during_mul", IN_READY, MUL_EN ? 0 : 1);
      end
      wait_drain(50);

      rdy_force = 1'b0;
      issue(0, 'hF0F0, 'h3C3C, w);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         #3 chk("in_ready_backpressure", IN_READY, 0);
      end
      rdy_force = 1'b1;
      issue(7, 'hAAAA, 'h0F0F, w);
      chk("drain_and_accept_same_cycle", w, 0);
      for (int i = 0; i < 4; i++) begin
         issue(6 + i, i + 1, 'h8421, w);
         chk("back_to_back_accept", w, 0);
      end
      wait_drain(50);

      issue(10, 'h0012, 'h0034, w);
      repeat (6) @(negedge CLK);
      #2 RST_N = 1'b0;
      #1 chk("async_reset_outputs", {IN_READY, OUT_VALID, OUT, ZERO, EQUAL, CARRY, NEG, OVF, ILLEGAL}, 0);
      sbq.delete();
      @(negedge CLK);
      RST_N = 1'b1;
      issue(2, 1, 1, w);
      wait_drain(50);

      rdy_rand = 1'b1;
      for (int i = 0; i < 300; i++) begin
         op = int'($urandom_range(0, 15));
         a = int'($urandom_range(0, 65535));
         b = int'($urandom_range(0, 65535));
         if ((op == 4 || op == 8 || op == 9) && $urandom_range(0, 3) != 0) a = int'($urandom_range(0, 20));
         if ($urandom_range(0, 15) == 0) b = a;
         issue(op, a, b, w);
      end
      rdy_rand = 1'b0;
      rdy_force = 1'b1;
      wait_drain(200);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
